pipe_control: RTL and testbench
===============================

PIPE_CONTROL -- requirements
Module: pipe_control

Interface
REQ-001 The module SHALL expose parameter DATA_WIDTH, default 32, instruction width.
REQ-002 The module SHALL expose parameter SIZEOP, default 6, opcode field width (bits [31:26]).
REQ-003 The module SHALL expose parameter REG_ADDR, default 5, register-specifier width (rs=[25:21], rt=[20:16]).
REQ-004 The module SHALL have ports, one per line:
- i_clock  in  1  single clock, all state on rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_instruccion  in  DATA_WIDTH  instruction currently in ID.
- i_valid  in  1  i_instruccion holds a real instruction.
- i_enable  in  1  global advance; low freezes all state (debug step).
- i_flush  in  1  branch taken; squash the instructions in ID and EX.
- o_ex  out  4  {RegDst, ALUSrc, ALUOp[1:0]} of the instruction in EX.
- o_mem  out  3  {MemRead, MemWrite, Branch} of the instruction in MEM.
- o_wb  out  2  {RegWrite, MemtoReg} of the instruction in WB; MemtoReg=1 selects ALU result.
- o_jump  out  1  combinational: the instruction in ID is J.
- o_stall  out  1  combinational: hold PC and IF/ID this cycle.
- o_illegal  out  1  combinational: valid ID opcode is not decoded.

Function
REQ-005 Decode SHALL be as follows (ex/mem/wb), with no don't-care bits:
- R_TYPE 000000: 1010/000/11.
- LW 100011: 0100/100/10.
- SW 101011: 0100/010/00.
- BEQ 000100: 0001/001/00.
- ADDI 001000: 0111/000/11.
- J 000010: 0000/000/00, with o_jump=1.
- Any other opcode: 0000/000/00, with o_illegal=i_valid.
REQ-006 Bundles SHALL pass through three registers: ID/EX {ex,mem,wb,rt,valid}, EX/MEM {mem,wb,valid}, MEM/WB {wb,valid}.
REQ-007 Latency SHALL be as follows for an instruction in ID in cycle N with no stall or flush: o_ex in cycle N+1, o_mem in N+2, o_wb in N+3.
REQ-008 A stage whose valid bit is 0 (bubble) SHALL drive all-zero outputs.
REQ-009 Load-use hazard SHALL be: ID/EX.valid AND ID/EX.MemRead AND ID/EX.rt!=0 AND (ID/EX.rt==ID.rs OR (ID opcode in {R_TYPE,SW,BEQ} AND ID/EX.rt==ID.rt)) AND i_valid.
REQ-010 o_stall SHALL equal load-use hazard AND NOT i_flush.
REQ-011 On a stall edge, ID/EX SHALL load a bubble while EX/MEM and MEM/WB advance normally; the stall SHALL last exactly one cycle per hazard.
REQ-012 On an i_flush edge, ID/EX and EX/MEM SHALL load bubbles, MEM/WB SHALL advance normally, and the stall condition SHALL be ignored.
REQ-013 With i_valid=0 and no flush, ID/EX SHALL load a bubble.
REQ-014 With i_enable=0, all registers SHALL hold; o_stall, o_jump and o_illegal SHALL remain combinational.
REQ-015 Priority SHALL be reset > i_enable=0 > i_flush > stall > normal advance.
REQ-016 o_jump and o_illegal SHALL be gated by i_valid.

Reset
REQ-017 i_reset low SHALL immediately clear all valid bits and bundle registers, without waiting for a clock edge.
REQ-018 During and after reset, o_ex=0000, o_mem=000, o_wb=00; o_stall SHALL be 0 until a valid LW reaches EX.
REQ-019 Deassertion of i_reset SHALL take effect at the next rising edge; reset asserted mid-pipeline SHALL discard all in-flight bundles.

Verification
REQ-020 LW then R_TYPE streaming (LW rt=5; next add with rs=5) SHALL produce o_stall=1 for exactly one cycle, o_ex=0000 in the bubble cycle, then o_ex=1010 for the add.
REQ-021 LW rt=0 followed by a consumer of rs=0 SHALL produce o_stall=0 throughout.
REQ-022 A sequence R,LW,SW,BEQ,ADDI, one per cycle, SHALL give o_ex 1010,0100,0100,0001,0111 on cycles 1-5, o_mem 000,100,010,001,000 on cycles 2-6, and o_wb 11,10,00,00,11 on cycles 3-7.
REQ-023 i_flush pulsed while BEQ is in EX/MEM and an R_TYPE is in ID/EX SHALL make o_mem=000 and o_ex=0000 next cycle, while the older MEM/WB o_wb value is still delivered.
REQ-024 A hazard cycle with i_flush=1 SHALL give o_stall=0 and bubbles per REQ-012.
REQ-025 i_enable=0 for 3 cycles mid-stream SHALL hold o_ex/o_mem/o_wb constant; i_reset asserted asynchronously mid-cycle SHALL zero all outputs before the next edge.

Source files
------------

// File: rtl/pipe_control.sv
// Main-control pipeline for ID/EX/MEM/WB: decodes the opcode in ID and carries EX/MEM/WB control bundles down the pipe.
// Latency: o_ex, o_mem and o_wb follow ID by 1, 2 and 3 cycles; o_jump, o_stall and o_illegal are combinational.
// Backpressure: a load-use hazard stalls PC and IF/ID for one cycle and puts a bubble into EX; i_enable low freezes every stage.
module pipe_control #(
  parameter int DATA_WIDTH = 32,
  parameter int SIZEOP     = 6,
  parameter int REG_ADDR   = 5
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_instruccion,
  input  logic                  i_valid,
  input  logic                  i_enable,
  input  logic                  i_flush,
  output logic [3:0]            o_ex,
  output logic [2:0]            o_mem,
  output logic [1:0]            o_wb,
  output logic                  o_jump,
  output logic                  o_stall,
  output logic                  o_illegal
);

  localparam int OP_LSB = DATA_WIDTH - SIZEOP;
  localparam int RS_LSB = OP_LSB - REG_ADDR;
  localparam int RT_LSB = RS_LSB - REG_ADDR;

  localparam logic [SIZEOP-1:0] OP_R    = SIZEOP'(6'b000000);
  localparam logic [SIZEOP-1:0] OP_LW   = SIZEOP'(6'b100011);
  localparam logic [SIZEOP-1:0] OP_SW   = SIZEOP'(6'b101011);
  localparam logic [SIZEOP-1:0] OP_BEQ  = SIZEOP'(6'b000100);
  localparam logic [SIZEOP-1:0] OP_ADDI = SIZEOP'(6'b001000);
  localparam logic [SIZEOP-1:0] OP_J    = SIZEOP'(6'b000010);

  // ex = {RegDst, ALUSrc, ALUOp[1:0]}, mem = {MemRead, MemWrite, Branch}, wb = {RegWrite, MemtoReg}
  typedef struct packed {
    logic [3:0] ex;
    logic [2:0] mem;
    logic [1:0] wb;
  } ctrl_t;

  typedef struct packed {
    ctrl_t               ctrl;
    logic [REG_ADDR-1:0] rt;
    logic                vld;
  } idex_t;

  typedef struct packed {
    logic [2:0] mem;
    logic [1:0] wb;
    logic       vld;
  } exmem_t;

  typedef struct packed {
    logic [1:0] wb;
    logic       vld;
  } memwb_t;

  logic [SIZEOP-1:0]   id_op;
  logic [REG_ADDR-1:0] id_rs;
  logic [REG_ADDR-1:0] id_rt;
  logic                unused_imm;

  assign id_op      = i_instruccion[DATA_WIDTH-1:OP_LSB];
  assign id_rs      = i_instruccion[OP_LSB-1:RS_LSB];
  assign id_rt      = i_instruccion[RS_LSB-1:RT_LSB];
  assign unused_imm = ^i_instruccion[RT_LSB-1:0];

  ctrl_t id_ctrl;
  logic  id_known;
  logic  id_is_j;
  logic  id_uses_rt;

  always_comb begin
    id_ctrl    = '0;
    id_known   = 1'b1;
    id_is_j    = 1'b0;
    id_uses_rt = 1'b0;
    case (id_op)
      OP_R: begin
        id_ctrl    = {4'b1010, 3'b000, 2'b11};
        id_uses_rt = 1'b1;
      end
      OP_LW:   id_ctrl = {4'b0100, 3'b100, 2'b10};
      OP_SW: begin
        id_ctrl    = {4'b0100, 3'b010, 2'b00};
        id_uses_rt = 1'b1;
      end
      OP_BEQ: begin
        id_ctrl    = {4'b0001, 3'b001, 2'b00};
        id_uses_rt = 1'b1;
      end
      OP_ADDI: id_ctrl = {4'b0111, 3'b000, 2'b11};
      OP_J:    id_is_j = 1'b1;
      default: id_known = 1'b0;
    endcase
  end

  idex_t  idex_q,  idex_d;
  exmem_t exmem_q, exmem_d;
  memwb_t memwb_q, memwb_d;

  // ADDI and LW only read rs, so rt is compared only for R_TYPE, SW and BEQ
  logic load_use;
  assign load_use = idex_q.vld && idex_q.ctrl.mem[2] && (idex_q.rt != '0) &&
                    ((idex_q.rt == id_rs) || (id_uses_rt && (idex_q.rt == id_rt))) &&
                    i_valid;

  assign o_stall   = load_use && !i_flush;
  assign o_jump    = i_valid && id_is_j;
  assign o_illegal = i_valid && !id_known;

  always_comb begin
    idex_d  = idex_q;
    exmem_d = exmem_q;
    memwb_d = memwb_q;
    if (i_enable) begin
      memwb_d = '{wb: exmem_q.wb, vld: exmem_q.vld};
      if (i_flush) begin
        idex_d  = '0;
        exmem_d = '0;
      end else begin
        exmem_d = '{mem: idex_q.ctrl.mem, wb: idex_q.ctrl.wb, vld: idex_q.vld};
        if (load_use || !i_valid) begin
          idex_d = '0;
        end else begin
          idex_d = '{ctrl: id_ctrl, rt: id_rt, vld: 1'b1};
        end
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  assign o_ex  = idex_q.vld  ? idex_q.ctrl.ex : 4'b0000;
  assign o_mem = exmem_q.vld ? exmem_q.mem    : 3'b000;
  assign o_wb  = memwb_q.vld ? memwb_q.wb     : 2'b00;

endmodule

// File: tb/tb_pipe_control.sv
// Directed bench for pipe_control: decode, pipeline latency, load-use stall, flush, freeze and async reset.
module tb_pipe_control;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic [31:0] i_instruccion;
  logic        i_valid;
  logic        i_enable;
  logic        i_flush;
  logic [3:0]  o_ex;
  logic [2:0]  o_mem;
  logic [1:0]  o_wb;
  logic        o_jump;
  logic        o_stall;
  logic        o_illegal;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] pipe_out;
  assign pipe_out = {o_ex, o_mem, o_wb};

  pipe_control #(.DATA_WIDTH(32), .SIZEOP(6), .REG_ADDR(5)) dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_instruccion (i_instruccion),
    .i_valid       (i_valid),
    .i_enable      (i_enable),
    .i_flush       (i_flush),
    .o_ex          (o_ex),
    .o_mem         (o_mem),
    .o_wb          (o_wb),
    .o_jump        (o_jump),
    .o_stall       (o_stall),
    .o_illegal     (o_illegal)
  );

  always #5 i_clock = ~i_clock;

  function automatic logic [31:0] ins(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt);
    return {op, rs, rt, 16'h1234};
  endfunction

  // inputs change 1 time unit after the rising edge; checks happen 3 units later
  task automatic next_cycle();
    @(posedge i_clock);
    #1;
  endtask

  task automatic drain();
    i_valid = 1'b0; i_flush = 1'b0; i_enable = 1'b1; i_instruccion = '0;
    repeat (4) next_cycle();
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if ({pipe_out, o_stall} !== 10'b0) begin
      n_fail++; $display("FAIL reset_outputs: got %b required %b", {pipe_out, o_stall}, 10'b0);
    end
    next_cycle();
    #3;
    n_checks++;
    if ({pipe_out, o_stall} !== 10'b0) begin
      n_fail++; $display("FAIL reset_held_after_edge: got %b required %b", {pipe_out, o_stall}, 10'b0);
    end
    i_reset = 1'b1; i_valid = 1'b0;
    next_cycle();
    n_checks++;
    if (pipe_out !== 9'b0) begin
      n_fail++; $display("FAIL reset_release: got %b required %b", pipe_out, 9'b0);
    end
  endtask

  task automatic test_sequence();
    logic [31:0] seq    [5];
    logic [3:0]  exp_ex [5];
    logic [2:0]  exp_mem[5];
    logic [1:0]  exp_wb [5];
    logic [8:0]  exp;
    seq[0] = ins(OP_R, 1, 2);    exp_ex[0] = 4'b1010; exp_mem[0] = 3'b000; exp_wb[0] = 2'b11;
    seq[1] = ins(OP_LW, 1, 3);   exp_ex[1] = 4'b0100; exp_mem[1] = 3'b100; exp_wb[1] = 2'b10;
    seq[2] = ins(OP_SW, 1, 2);   exp_ex[2] = 4'b0100; exp_mem[2] = 3'b010; exp_wb[2] = 2'b00;
    seq[3] = ins(OP_BEQ, 1, 2);  exp_ex[3] = 4'b0001; exp_mem[3] = 3'b001; exp_wb[3] = 2'b00;
    seq[4] = ins(OP_ADDI, 1, 4); exp_ex[4] = 4'b0111; exp_mem[4] = 3'b000; exp_wb[4] = 2'b11;
    drain();
    for (int c = 0; c < 8; c++) begin
      i_valid       = (c < 5);
      i_instruccion = (c < 5) ? seq[c] : 32'h0;
      #3;
      exp = '0;
      if (c >= 1 && c <= 5) exp[8:5] = exp_ex[c-1];
      if (c >= 2 && c <= 6) exp[4:2] = exp_mem[c-2];
      if (c >= 3 && c <= 7) exp[1:0] = exp_wb[c-3];
      n_checks++;
      if ({pipe_out, o_stall, o_jump, o_illegal} !== {exp, 3'b000}) begin
        n_fail++;
        $display("FAIL seq_cycle%0d: got %b required %b", c, {pipe_out, o_stall, o_jump, o_illegal}, {exp, 3'b000});
      end
      next_cycle();
    end
  endtask

  task automatic test_load_use();
    drain();
    i_valid = 1'b1; i_instruccion = ins(OP_LW, 1, 5);
    #3;
    n_checks++;
    if (o_stall !== 1'b0) begin n_fail++; $display("FAIL lu_no_stall_lw_in_id: got %b required 0", o_stall); end
    next_cycle();
    i_instruccion = ins(OP_R, 5, 6);
    #3;
    n_checks++;
    if ({o_stall, pipe_out} !== {1'b1, 4'b0100, 3'b000, 2'b00}) begin
      n_fail++; $display("FAIL lu_stall_cycle: got %b required %b", {o_stall, pipe_out}, {1'b1, 9'b0100_000_00});
    end
    next_cycle();
    #3;
    n_checks++;
    if ({o_stall, pipe_out} !== {1'b0, 4'b0000, 3'b100, 2'b00}) begin
      n_fail++; $display("FAIL lu_bubble_cycle: got %b required %b", {o_stall, pipe_out}, {1'b0, 9'b0000_100_00});
    end
    next_cycle();
    i_valid = 1'b0;
    #3;
    n_checks++;
    if (pipe_out !== {4'b1010, 3'b000, 2'b10}) begin
      n_fail++; $display("FAIL lu_add_in_ex: got %b required %b", pipe_out, 9'b1010_000_10);
    end
    next_cycle();
    i_valid = 1'b1; i_instruccion = ins(OP_LW, 1, 7);
    next_cycle();
    i_instruccion = ins(OP_SW, 2, 7);
    #1;
    n_checks++;
    if (o_stall !== 1'b1) begin n_fail++; $display("FAIL lu_sw_rt_match: got %b required 1", o_stall); end
    i_instruccion = ins(OP_ADDI, 2, 7);
    #1;
    n_checks++;
    if (o_stall !== 1'b0) begin n_fail++; $display("FAIL lu_addi_rt_ignored: got %b required 0", o_stall); end
    i_instruccion = ins(OP_LW, 7, 2);
    #1;
    n_checks++;
    if (o_stall !== 1'b1) begin n_fail++; $display("FAIL lu_lw_rs_match: got %b required 1", o_stall); end
    i_valid = 1'b0;
    #1;
    n_checks++;
    if (o_stall !== 1'b0) begin n_fail++; $display("FAIL lu_invalid_id: got %b required 0", o_stall); end
  endtask

  task automatic test_rt_zero();
    drain();
    i_valid = 1'b1; i_instruccion = ins(OP_LW, 1, 0);
    next_cycle();
    i_instruccion = ins(OP_R, 0, 0);
    #3;
    n_checks++;
    if (o_stall !== 1'b0) begin n_fail++; $display("FAIL rt0_no_stall: got %b required 0", o_stall); end
    next_cycle();
    i_valid = 1'b0;
    #3;
    n_checks++;
    if ({o_stall, o_ex, o_mem} !== {1'b0, 4'b1010, 3'b100}) begin
      n_fail++; $display("FAIL rt0_add_follows: got %b required %b", {o_stall, o_ex, o_mem}, 8'b0_1010_100);
    end
  endtask

  task automatic test_flush();
    drain();
    i_valid = 1'b1;
    i_instruccion = ins(OP_ADDI, 1, 4); next_cycle();
    i_instruccion = ins(OP_LW, 1, 9);   next_cycle();
    i_instruccion = ins(OP_BEQ, 1, 2);  next_cycle();
    i_instruccion = ins(OP_R, 1, 2);    next_cycle();
    i_instruccion = ins(OP_LW, 1, 6);
    i_flush = 1'b1;
    #3;
    n_checks++;
    if ({o_stall, pipe_out} !== {1'b0, 4'b1010, 3'b001, 2'b10}) begin
      n_fail++; $display("FAIL flush_cycle: got %b required %b", {o_stall, pipe_out}, {1'b0, 9'b1010_001_10});
    end
    next_cycle();
    i_flush = 1'b0; i_valid = 1'b0;
    #3;
    n_checks++;
    if (pipe_out !== 9'b0) begin
      n_fail++; $display("FAIL flush_squashed: got %b required %b", pipe_out, 9'b0);
    end
    next_cycle();
    #3;
    n_checks++;
    if (pipe_out !== 9'b0) begin
      n_fail++; $display("FAIL flush_after: got %b required %b", pipe_out, 9'b0);
    end
  endtask

  task automatic test_flush_hazard();
    drain();
    i_valid = 1'b1;
    i_instruccion = ins(OP_LW, 1, 4); next_cycle();
    i_instruccion = ins(OP_LW, 1, 5); next_cycle();
    i_instruccion = ins(OP_R, 5, 6);
    #1;
    n_checks++;
    if (o_stall !== 1'b1) begin n_fail++; $display("FAIL fh_hazard_present: got %b required 1", o_stall); end
    i_flush = 1'b1;
    #2;
    n_checks++;
    if ({o_stall, pipe_out} !== {1'b0, 4'b0100, 3'b100, 2'b00}) begin
      n_fail++; $display("FAIL fh_flush_masks_stall: got %b required %b", {o_stall, pipe_out}, {1'b0, 9'b0100_100_00});
    end
    next_cycle();
    i_flush = 1'b0; i_valid = 1'b0;
    #3;
    n_checks++;
    if ({o_stall, pipe_out} !== {1'b0, 4'b0000, 3'b000, 2'b10}) begin
      n_fail++; $display("FAIL fh_memwb_advanced: got %b required %b", {o_stall, pipe_out}, {1'b0, 9'b0000_000_10});
    end
  endtask

  task automatic test_enable();
    logic [8:0] held;
    drain();
    i_valid = 1'b1;
    i_instruccion = ins(OP_R, 1, 2);  next_cycle();
    i_instruccion = ins(OP_SW, 1, 2); next_cycle();
    i_instruccion = ins(OP_LW, 1, 3); next_cycle();
    i_instruccion = ins(OP_R, 3, 4);
    i_enable = 1'b0;
    held = {4'b0100, 3'b010, 2'b11};
    for (int k = 0; k < 3; k++) begin
      if (k == 1) begin
        i_instruccion = ins(OP_J, 0, 0);
        #1;
        n_checks++;
        if ({o_jump, o_illegal} !== 2'b10) begin
          n_fail++; $display("FAIL en_frozen_jump: got %b required 10", {o_jump, o_illegal});
        end
        i_instruccion = ins(6'b111111, 3, 4);
        #1;
        n_checks++;
        if ({o_jump, o_illegal} !== 2'b01) begin
          n_fail++; $display("FAIL en_frozen_illegal: got %b required 01", {o_jump, o_illegal});
        end
        i_instruccion = ins(OP_R, 3, 4);
        #1;
      end else begin
        #3;
      end
      n_checks++;
      if ({o_stall, pipe_out} !== {1'b1, held}) begin
        n_fail++; $display("FAIL en_frozen_cycle%0d: got %b required %b", k, {o_stall, pipe_out}, {1'b1, held});
      end
      next_cycle();
    end
    i_enable = 1'b1;
    #3;
    n_checks++;
    if ({o_stall, pipe_out} !== {1'b1, held}) begin
      n_fail++; $display("FAIL en_resume: got %b required %b", {o_stall, pipe_out}, {1'b1, held});
    end
    next_cycle();
    #3;
    n_checks++;
    if ({o_stall, pipe_out} !== {1'b0, 4'b0000, 3'b100, 2'b00}) begin
      n_fail++; $display("FAIL en_after_stall: got %b required %b", {o_stall, pipe_out}, {1'b0, 9'b0000_100_00});
    end
    next_cycle();
    i_valid = 1'b0;
    #3;
    n_checks++;
    if (pipe_out !== {4'b1010, 3'b000, 2'b10}) begin
      n_fail++; $display("FAIL en_consumer_in_ex: got %b required %b", pipe_out, 9'b1010_000_10);
    end
  endtask

  task automatic test_jump_illegal();
    drain();
    i_valid = 1'b1; i_instruccion = ins(OP_J, 0, 0);
    #1;
    n_checks++;
    if ({o_jump, o_illegal} !== 2'b10) begin n_fail++; $display("FAIL ji_jump: got %b required 10", {o_jump, o_illegal}); end
    i_valid = 1'b0;
    #1;
    n_checks++;
    if ({o_jump, o_illegal} !== 2'b00) begin n_fail++; $display("FAIL ji_jump_gated: got %b required 00", {o_jump, o_illegal}); end
    i_valid = 1'b1; i_instruccion = ins(6'b000011, 1, 2);
    #1;
    n_checks++;
    if ({o_jump, o_illegal} !== 2'b01) begin n_fail++; $display("FAIL ji_illegal: got %b required 01", {o_jump, o_illegal}); end
    i_valid = 1'b0;
    #1;
    n_checks++;
    if ({o_jump, o_illegal} !== 2'b00) begin n_fail++; $display("FAIL ji_illegal_gated: got %b required 00", {o_jump, o_illegal}); end
    i_valid = 1'b1; i_instruccion = ins(OP_J, 0, 0);
    next_cycle();
    i_valid = 1'b0;
    #3;
    n_checks++;
    if (o_ex !== 4'b0000) begin n_fail++; $display("FAIL ji_jump_ex_zero: got %b required 0000", o_ex); end
  endtask

  task automatic test_async_reset();
    drain();
    i_valid = 1'b1;
    i_instruccion = ins(OP_R, 1, 2);  next_cycle();
    i_instruccion = ins(OP_LW, 1, 3); next_cycle();
    i_instruccion = ins(OP_R, 3, 4);
    #3;
    n_checks++;
    if ({o_stall, pipe_out} !== {1'b1, 4'b0100, 3'b000, 2'b00}) begin
      n_fail++; $display("FAIL ar_before: got %b required %b", {o_stall, pipe_out}, {1'b1, 9'b0100_000_00});
    end
    #2;
    i_reset = 1'b0;
    #1;
    n_checks++;
    if ({o_stall, pipe_out} !== 10'b0) begin
      n_fail++; $display("FAIL ar_immediate_clear: got %b required %b", {o_stall, pipe_out}, 10'b0);
    end
    next_cycle();
    #2;
    i_reset = 1'b1;
    i_instruccion = ins(OP_LW, 1, 3);
    #1;
    n_checks++;
    if ({o_stall, pipe_out} !== 10'b0) begin
      n_fail++; $display("FAIL ar_released_empty: got %b required %b", {o_stall, pipe_out}, 10'b0);
    end
    next_cycle();
    i_instruccion = ins(OP_R, 3, 4);
    #3;
    n_checks++;
    if ({o_stall, o_ex, o_mem} !== {1'b1, 4'b0100, 3'b000}) begin
      n_fail++; $display("FAIL ar_resumes: got %b required %b", {o_stall, o_ex, o_mem}, 8'b1_0100_000);
    end
    i_valid = 1'b0;
  endtask

  initial begin
    i_reset       = 1'b0;
    i_enable      = 1'b1;
    i_flush       = 1'b0;
    i_valid       = 1'b1;
    i_instruccion = ins(OP_LW, 1, 3);
    test_reset();
    test_sequence();
    test_load_use();
    test_rt_zero();
    test_flush();
    test_flush_hazard();
    test_enable();
    test_jump_illegal();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1);
  end

endmodule
